// File: rtl/alu_serial_pkg.sv
// Shared types for the bit-serial ALU sequencer: control codes, FSM states,
// slice op encodings and the control-code decoder.
package alu_serial_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_ADD  = 2'b10,
        OP_RSVD = 2'b11
    } slice_op_t;

    typedef struct packed {
        logic      supported;
        logic      a_inv;
        logic      b_inv;
        logic      cin;
        slice_op_t op;
        logic      is_slt;
    } slice_ctrl_t;

    function automatic slice_ctrl_t decode_ctrl(input logic [3:0] ctrl);
        slice_ctrl_t d;
        d    = '0;
        d.op = OP_AND;
        case (ctrl)
            CTRL_AND: d.supported = 1'b1;
            CTRL_OR: begin
                d.supported = 1'b1;
                d.op        = OP_OR;
            end
            CTRL_ADD: begin
                d.supported = 1'b1;
                d.op        = OP_ADD;
            end
            CTRL_SUB: begin
                d.supported = 1'b1;
                d.b_inv     = 1'b1;
                d.cin       = 1'b1;
                d.op        = OP_ADD;
            end
            CTRL_SLT: begin
                d.supported = 1'b1;
                d.b_inv     = 1'b1;
                d.cin       = 1'b1;
                d.op        = OP_ADD;
                d.is_slt    = 1'b1;
            end
            CTRL_NOR: begin
                d.supported = 1'b1;
                d.a_inv     = 1'b1;
                d.b_inv     = 1'b1;
            end
            default: d.supported = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: AND / OR / full-add with operand inverts.
module alu_bit_slice
    import alu_serial_pkg::*;
(
    input  logic      a,
    input  logic      b,
    input  logic      a_inv,
    input  logic      b_inv,
    input  logic      cin,
    input  slice_op_t op,
    output logic      result,
    output logic      cout
);

    logic a_eff;
    logic b_eff;

    assign a_eff = a ^ a_inv;
    assign b_eff = b ^ b_inv;
    assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);

    always_comb begin
        result = 1'b0;
        case (op)
            OP_AND:  result = a_eff & b_eff;
            OP_OR:   result = a_eff | b_eff;
            OP_ADD:  result = a_eff ^ b_eff ^ cin;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer driving one alu_bit_slice, LSB first.
// Flag outputs (zero/cout/overflow) exist only when ALU_SERIAL_FLAGS_EN is defined.
//
// state   | meaning
// IDLE    | ready for a request
// RUN     | one bit per clock through the slice
// DONE    | result valid, held until consumed
module alu_serial_ctrl
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    state_t state_q;
    state_t state_d;

    slice_ctrl_t dec_in;
    logic [WIDTH-1:0] src1_q;
    logic [WIDTH-1:0] src2_q;
    logic [WIDTH-1:0] result_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q;
    logic             a_inv_q;
    logic             b_inv_q;
    logic             is_slt_q;
    slice_op_t        op_q;

    logic             slice_res;
    logic             slice_cout;
    logic             msb_ovf;
    logic             at_msb;
    logic [WIDTH-1:0] final_word;

    assign dec_in = decode_ctrl(ctrl_i);
    assign at_msb = (idx_q == IDX_LAST);

    alu_bit_slice u_slice (
        .a      (src1_q[idx_q]),
        .b      (src2_q[idx_q]),
        .a_inv  (a_inv_q),
        .b_inv  (b_inv_q),
        .cin    (carry_q),
        .op     (op_q),
        .result (slice_res),
        .cout   (slice_cout)
    );

    // Word as it will stand once the MSB lands; SLT collapses to the set bit.
    always_comb begin
        msb_ovf                = carry_q ^ slice_cout;
        final_word             = result_q;
        final_word[WIDTH-1]    = slice_res;
        if (is_slt_q) begin
            final_word    = '0;
            final_word[0] = slice_res ^ msb_ovf;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    state_d = dec_in.supported ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (at_msb) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = (state_q == ST_IDLE);
        out_valid_o = (state_q == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            src1_q   <= '0;
            src2_q   <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_inv_q  <= 1'b0;
            b_inv_q  <= 1'b0;
            is_slt_q <= 1'b0;
            op_q     <= OP_AND;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        src1_q   <= src1_i;
                        src2_q   <= src2_i;
                        result_q <= '0;
                        idx_q    <= '0;
                        carry_q  <= dec_in.cin;
                        a_inv_q  <= dec_in.a_inv;
                        b_inv_q  <= dec_in.b_inv;
                        is_slt_q <= dec_in.is_slt;
                        op_q     <= dec_in.op;
                    end
                end
                ST_RUN: begin
                    carry_q <= slice_cout;
                    idx_q   <= idx_q + 1'b1;
                    if (at_msb) begin
                        result_q <= final_word;
                    end else begin
                        result_q[idx_q] <= slice_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result_o = result_q;

`ifdef ALU_SERIAL_FLAGS_EN
    logic zero_q;
    logic cout_q;
    logic ovf_q;
    logic is_arith;

    assign is_arith = (op_q == OP_ADD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            zero_q <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        zero_q <= ~dec_in.supported;
                        cout_q <= 1'b0;
                        ovf_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (at_msb) begin
                        zero_q <= (final_word == '0);
                        cout_q <= is_arith & slice_cout;
                        ovf_q  <= is_arith & ~is_slt_q & msb_ovf;
                    end
                end
                default: ;
            endcase
        end
    end

    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;
`else
    assign zero_o     = 1'b0;
    assign cout_o     = 1'b0;
    assign overflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed-vector bench for alu_serial_ctrl; flag expectations follow ALU_SERIAL_FLAGS_EN.
module tb_alu_serial_ctrl;

`ifdef ALU_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;

    int n_checks = 0;
    int n_pass   = 0;

    alu_serial_ctrl #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .src1_i      (src1),
        .src2_i      (src2),
        .ctrl_i      (ctrl),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .result_o    (result),
        .zero_o      (zero),
        .cout_o      (cout),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    endtask

    function automatic logic fl(input logic v);
        return FLAGS & v;
    endfunction

    // Present a request, return edges from accept until out_valid is seen.
    task automatic issue(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, output int lat);
        @(negedge clk);
        ctrl     = c;
        src1     = a;
        src2     = b;
        in_valid = 1'b1;
        check({tag, " ready_pre"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, " ready_post"}, {31'd0, in_ready}, 32'd1);
        check({tag, " valid_post"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want_res,
                         input logic ez, input logic ec, input logic eo, input int want_lat);
        int lat;
        issue(tag, c, a, b, lat);
        check({tag, " latency"}, lat, want_lat);
        check({tag, " result"}, result, want_res);
        check({tag, " zero"}, {31'd0, zero}, {31'd0, fl(ez)});
        check({tag, " cout"}, {31'd0, cout}, {31'd0, fl(ec)});
        check({tag, " ovf"}, {31'd0, overflow}, {31'd0, fl(eo)});
        consume(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ctrl      = 4'b0000;
        src1      = '0;
        src2      = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst ready", {31'd0, in_ready}, 32'd1);
        check("rst valid", {31'd0, out_valid}, 32'd0);
        check("rst result", result, 32'd0);
        check("rst flags", {29'd0, zero, cout, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 0, 1, 32);
        do_op("sub_eq",  4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 1, 0, 32);
        do_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 0, 1, 0, 32);
        do_op("slt_ovf", 4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1, 0, 0, 32);
        do_op("nor",     4'b1100, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000, 0, 0, 0, 32);
        do_op("and",     4'b0000, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h000F_000F, 0, 0, 0, 32);
        do_op("or",      4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FFF_0FFF, 0, 0, 0, 32);
        // Unsupported code goes straight to DONE on the accept edge.
        do_op("unsup",   4'b1111, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0000_0000, 1, 0, 0, 0);

        // Back-pressure with a competing request that must be ignored.
        issue("bp", 4'b0010, 32'h0000_0001, 32'h0000_0002, lat);
        check("bp latency", lat, 32);
        @(negedge clk);
        in_valid = 1'b1;
        ctrl     = 4'b0001;
        src1     = 32'hAAAA_0000;
        src2     = 32'h0000_5555;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp hold result", result, 32'h0000_0003);
            check("bp hold valid", {31'd0, out_valid}, 32'd1);
            check("bp ready low", {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        consume("bp");
        @(posedge clk);
        #1;
        check("bp still idle", {31'd0, in_ready}, 32'd1);
        check("bp result kept", result, 32'h0000_0003);

        // Reset while bit 10 is in the slice.
        @(negedge clk);
        ctrl     = 4'b0010;
        src1     = 32'hFFFF_FFFF;
        src2     = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstrun valid", {31'd0, out_valid}, 32'd0);
        check("rstrun ready", {31'd0, in_ready}, 32'd1);
        check("rstrun result", result, 32'd0);
        check("rstrun flags", {29'd0, zero, cout, overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("add_after_rst", 4'b0010, 32'd3, 32'd4, 32'd7, 0, 0, 0, 32);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
